astropix3_asic_model_frame_arbiter: RTL and testbench

Frame-level round-robin arbiter in the ASIC model that shares one egress byte stream (the model's frame FIFO write port) between NSRC frame generators. A grant is held for a whole frame, from the first byte until the granted source drops its write. Byte transfer with the winning source is zero-latency pass-through. The block also drives the model's interrupt line and frame statistics for the model-control registers.

---
 rtl/astropix3_asic_model_frame_arbiter_pkg.sv | 19 +
 rtl/astropix3_asic_model_frame_arbiter_rr_pick.sv | 29 ++
 rtl/astropix3_asic_model_frame_arbiter.sv | 123 ++++++++++++
 tb/tb_astropix3_asic_model_frame_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/astropix3_asic_model_frame_arbiter_pkg.sv
// Shared types for the ASIC model frame path: data/counter types, arbiter state, helpers.
package astropix3_asic_model_frame_arbiter_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_GAP
    } arb_state_t;

    localparam word_t WORD_MAX = 16'hFFFF;

    function automatic word_t sat_inc(input word_t v);
        return (v == WORD_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/astropix3_asic_model_frame_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after i_last, wrapping modulo NSRC.
module astropix3_asic_model_frame_arbiter_rr_pick #(
    parameter int unsigned NSRC  = 2,
    parameter int unsigned IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    int unsigned w_cand;
    logic        w_found;

    always_comb begin
        w_found = 1'b0;
        w_cand  = 0;
        o_idx   = '0;
        for (int unsigned k = 1; k <= NSRC; k++) begin
            w_cand = (32'(i_last) + k) % NSRC;
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                o_idx   = IDX_W'(w_cand);
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/astropix3_asic_model_frame_arbiter.sv
// Frame-level round-robin arbiter sharing the model's frame FIFO write port between sources.
// A grant lasts a whole frame; the byte path in GRANT is a combinational pass-through.
module astropix3_asic_model_frame_arbiter
    import astropix3_asic_model_frame_arbiter_pkg::*;
#(
    parameter int unsigned NSRC  = 2,
    parameter int unsigned IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic              i_clk,
    input  logic              i_resn,
    input  logic              i_config_generate_interrupt,
    input  logic [NSRC-1:0]   i_src_frame_write,
    input  logic [NSRC*8-1:0] i_src_frame_data,
    output logic [NSRC-1:0]   o_src_frame_full,
    output logic              o_egress_frame_write,
    output byte_t             o_egress_frame_data,
    input  logic              i_egress_frame_full,
    output logic              o_interruptn,
    output logic              o_busy,
    output word_t             o_frames_done,
    output word_t             o_last_frame_len,
    output logic [IDX_W-1:0]  o_last_frame_src
);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_last_grant;
    word_t            r_byte_cnt;
    word_t            r_frames_done;
    word_t            r_last_frame_len;
    logic [IDX_W-1:0] r_last_frame_src;
    logic             r_interruptn;

    logic             w_pick_valid;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_grant_write;
    byte_t            w_grant_byte;
    logic             w_busy;

    astropix3_asic_model_frame_arbiter_rr_pick #(
        .NSRC  (NSRC),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req   (i_src_frame_write),
        .i_last  (r_last_grant),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // Mux of the granted source, written as a loop so the index width never matters.
    always_comb begin
        w_grant_write = 1'b0;
        w_grant_byte  = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (IDX_W'(i) == r_grant) begin
                w_grant_write = i_src_frame_write[i];
                w_grant_byte  = i_src_frame_data[8*i +: 8];
            end
        end
    end

    assign w_busy = (r_state != ARB_IDLE);

    always_comb begin
        o_src_frame_full     = '1;
        o_egress_frame_write = 1'b0;
        o_egress_frame_data  = '0;
        if (r_state == ARB_GRANT) begin
            o_egress_frame_write = w_grant_write;
            o_egress_frame_data  = w_grant_byte;
            for (int i = 0; i < int'(NSRC); i++) begin
                if (IDX_W'(i) == r_grant) begin
                    o_src_frame_full[i] = i_egress_frame_full;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resn) begin
            r_state          <= ARB_IDLE;
            r_grant          <= '0;
            r_last_grant     <= IDX_W'(NSRC - 1);
            r_byte_cnt       <= '0;
            r_frames_done    <= '0;
            r_last_frame_len <= '0;
            r_last_frame_src <= '0;
            r_interruptn     <= 1'b1;
        end else begin
            r_interruptn <= !(i_config_generate_interrupt && (w_busy || |i_src_frame_write));
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant    <= w_pick_idx;
                        r_byte_cnt <= '0;
                        r_state    <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    // Dropped write ends the frame, including a zero-byte one.
                    if (!w_grant_write) begin
                        r_last_frame_len <= r_byte_cnt;
                        r_last_frame_src <= r_grant;
                        r_last_grant     <= r_grant;
                        r_frames_done    <= r_frames_done + 16'd1;
                        r_state          <= ARB_GAP;
                    end else if (!i_egress_frame_full) begin
                        r_byte_cnt <= sat_inc(r_byte_cnt);
                    end
                end
                ARB_GAP: r_state <= ARB_IDLE;
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign o_interruptn     = r_interruptn;
    assign o_busy           = w_busy;
    assign o_frames_done    = r_frames_done;
    assign o_last_frame_len = r_last_frame_len;
    assign o_last_frame_src = r_last_frame_src;

endmodule

// File: tb/tb_astropix3_asic_model_frame_arbiter.sv
// Directed bench for the frame arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_astropix3_asic_model_frame_arbiter;

    logic        clk = 1'b0;
    logic        resn;
    logic        cfg_int;
    logic [1:0]  src_wr;
    logic [15:0] src_data;
    logic [1:0]  src_full;
    logic        eg_wr;
    logic [7:0]  eg_data;
    logic        eg_full;
    logic        intn;
    logic        busy;
    logic [15:0] frames_done;
    logic [15:0] last_len;
    logic [0:0]  last_src;

    int n_checks = 0;
    int n_errs   = 0;

    astropix3_asic_model_frame_arbiter #(
        .NSRC  (2),
        .IDX_W (1)
    ) dut (
        .i_clk                       (clk),
        .i_resn                      (resn),
        .i_config_generate_interrupt (cfg_int),
        .i_src_frame_write           (src_wr),
        .i_src_frame_data            (src_data),
        .o_src_frame_full            (src_full),
        .o_egress_frame_write        (eg_wr),
        .o_egress_frame_data         (eg_data),
        .i_egress_frame_full         (eg_full),
        .o_interruptn                (intn),
        .o_busy                      (busy),
        .o_frames_done               (frames_done),
        .o_last_frame_len            (last_len),
        .o_last_frame_src            (last_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wr;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic        full;
        logic        exp_ew;
        logic [7:0]  exp_ed;
        logic [1:0]  exp_sf;
        logic        exp_busy;
        logic        chk_st;
        logic [15:0] exp_fd;
        logic [15:0] exp_len;
        logic        exp_src;
    } vec_t;

    vec_t vecs[32];
    int   n_vec = 0;

    task automatic add(input logic [1:0] wr, input logic [7:0] d0, input logic [7:0] d1,
                       input logic full, input logic ew, input logic [7:0] ed,
                       input logic [1:0] sf, input logic bsy, input logic chk,
                       input logic [15:0] fd, input logic [15:0] len, input logic srcx);
        vecs[n_vec] = '{wr, d0, d1, full, ew, ed, sf, bsy, chk, fd, len, srcx};
        n_vec++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resn     = 1'b0;
        src_wr   = 2'b00;
        src_data = 16'h0000;
        eg_full  = 1'b0;
        tick();
        tick();
        resn = 1'b1;
    endtask

    int cycles, frames, nbytes, idle_run, cur, g;

    initial begin
        cfg_int = 1'b0;
        do_reset();

        // Source 0: 4-byte frame
        add(2'b01, 8'h09, 8'h00, 0, 0, 8'h00, 2'b11, 0, 1, 16'd0, 16'd0, 0);
        add(2'b01, 8'h09, 8'h00, 0, 1, 8'h09, 2'b10, 1, 0, 0, 0, 0);
        add(2'b01, 8'h00, 8'h00, 0, 1, 8'h00, 2'b10, 1, 0, 0, 0, 0);
        add(2'b01, 8'h01, 8'h00, 0, 1, 8'h01, 2'b10, 1, 0, 0, 0, 0);
        add(2'b01, 8'h02, 8'h00, 0, 1, 8'h02, 2'b10, 1, 0, 0, 0, 0);
        add(2'b00, 8'h00, 8'h00, 0, 0, 8'h00, 2'b10, 1, 0, 0, 0, 0);
        add(2'b00, 8'h00, 8'h00, 0, 0, 8'h00, 2'b11, 1, 1, 16'd1, 16'd4, 0);
        add(2'b00, 8'h00, 8'h00, 0, 0, 8'h00, 2'b11, 0, 0, 0, 0, 0);
        // Source 1: 6-byte frame with FIFO full for 3 cycles mid-frame
        add(2'b10, 8'h00, 8'hA1, 0, 0, 8'h00, 2'b11, 0, 0, 0, 0, 0);
        add(2'b10, 8'h00, 8'hA1, 0, 1, 8'hA1, 2'b01, 1, 0, 0, 0, 0);
        add(2'b10, 8'h00, 8'hA2, 0, 1, 8'hA2, 2'b01, 1, 0, 0, 0, 0);
        add(2'b10, 8'h00, 8'hA3, 1, 1, 8'hA3, 2'b11, 1, 0, 0, 0, 0);
        add(2'b10, 8'h00, 8'hA3, 1, 1, 8'hA3, 2'b11, 1, 0, 0, 0, 0);
        add(2'b10, 8'h00, 8'hA3, 1, 1, 8'hA3, 2'b11, 1, 0, 0, 0, 0);
        add(2'b10, 8'h00, 8'hA3, 0, 1, 8'hA3, 2'b01, 1, 0, 0, 0, 0);
        add(2'b10, 8'h00, 8'hA4, 0, 1, 8'hA4, 2'b01, 1, 0, 0, 0, 0);
        add(2'b10, 8'h00, 8'hA5, 0, 1, 8'hA5, 2'b01, 1, 0, 0, 0, 0);
        add(2'b10, 8'h00, 8'hA6, 0, 1, 8'hA6, 2'b01, 1, 0, 0, 0, 0);
        add(2'b00, 8'h00, 8'h00, 0, 0, 8'h00, 2'b01, 1, 0, 0, 0, 0);
        add(2'b00, 8'h00, 8'h00, 0, 0, 8'h00, 2'b11, 1, 1, 16'd2, 16'd6, 1);
        add(2'b00, 8'h00, 8'h00, 0, 0, 8'h00, 2'b11, 0, 0, 0, 0, 0);
        // Zero-byte grant: write high for one cycle only
        add(2'b01, 8'h55, 8'h00, 0, 0, 8'h00, 2'b11, 0, 0, 0, 0, 0);
        add(2'b00, 8'h00, 8'h00, 0, 0, 8'h00, 2'b10, 1, 0, 0, 0, 0);
        add(2'b00, 8'h00, 8'h00, 0, 0, 8'h00, 2'b11, 1, 1, 16'd3, 16'd0, 0);
        add(2'b00, 8'h00, 8'h00, 0, 0, 8'h00, 2'b11, 0, 0, 0, 0, 0);

        chk("reset_intn", 32'(intn), 32'd1);
        for (int i = 0; i < n_vec; i++) begin
            src_wr   = vecs[i].wr;
            src_data = {vecs[i].d1, vecs[i].d0};
            eg_full  = vecs[i].full;
            @(negedge clk);
            chk($sformatf("v%0d_ew", i), 32'(eg_wr), 32'(vecs[i].exp_ew));
            chk($sformatf("v%0d_ed", i), 32'(eg_data), 32'(vecs[i].exp_ed));
            chk($sformatf("v%0d_sf", i), 32'(src_full), 32'(vecs[i].exp_sf));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            if (vecs[i].chk_st) begin
                chk($sformatf("v%0d_frames", i), 32'(frames_done), 32'(vecs[i].exp_fd));
                chk($sformatf("v%0d_len", i), 32'(last_len), 32'(vecs[i].exp_len));
                chk($sformatf("v%0d_src", i), 32'(last_src), 32'(vecs[i].exp_src));
            end
            tick();
        end

        // Both sources request continuously: 8 two-byte frames, alternating 0,1,0,1...
        do_reset();
        src_wr   = 2'b11;
        src_data = 16'h2010;
        frames   = 0;
        nbytes   = 0;
        idle_run = 0;
        cur      = 0;
        cycles   = 0;
        while (frames < 8 && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (eg_wr) begin
                g = src_full[0] ? 1 : 0;
                if (nbytes == 0) begin
                    chk($sformatf("rr_order_f%0d", frames), 32'(g), 32'(frames % 2));
                    if (frames > 0) chk("rr_gap_ge2", 32'(idle_run >= 2), 32'd1);
                end else begin
                    chk("rr_no_interleave", 32'(g), 32'(cur));
                end
                chk("rr_data", 32'(eg_data), 32'(g ? src_data[15:8] : src_data[7:0]));
                cur      = g;
                nbytes++;
                idle_run = 0;
                tick();
                if (nbytes == 2) begin
                    src_wr[g] = 1'b0;
                    frames++;
                    nbytes = 0;
                end else if (g == 1) begin
                    src_data[15:8] = src_data[15:8] + 8'd1;
                end else begin
                    src_data[7:0] = src_data[7:0] + 8'd1;
                end
            end else begin
                idle_run++;
                tick();
                src_wr = 2'b11;
            end
        end
        chk("rr_frames_seen", 32'(frames), 32'd8);
        src_wr = 2'b00;
        tick();
        tick();
        chk("rr_frames_done", 32'(frames_done), 32'd8);

        // Interrupt: enabled, source 1 requests a zero-byte frame
        do_reset();
        cfg_int = 1'b1;
        tick();
        @(negedge clk);
        chk("int_idle", 32'(intn), 32'd1);
        tick();
        src_wr = 2'b10;
        @(negedge clk);
        chk("int_lag", 32'(intn), 32'd1);
        tick();
        src_wr = 2'b00;
        @(negedge clk);
        chk("int_assert", 32'(intn), 32'd0);
        tick();
        @(negedge clk);
        chk("int_gap", 32'(intn), 32'd0);
        tick();
        @(negedge clk);
        chk("int_idle_busy", 32'(busy), 32'd0);
        chk("int_still_low", 32'(intn), 32'd0);
        tick();
        @(negedge clk);
        chk("int_release", 32'(intn), 32'd1);
        cfg_int = 1'b0;
        src_wr  = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk($sformatf("int_disabled_%0d", i), 32'(intn), 32'd1);
        end

        // Reset during byte 2 of a source-1 frame
        tick();
        do_reset();
        src_wr   = 2'b10;
        src_data = 16'h3300;
        tick();
        @(negedge clk);
        chk("mid_b1_ew", 32'(eg_wr), 32'd1);
        tick();
        src_data = 16'h3400;
        resn     = 1'b0;
        @(negedge clk);
        chk("mid_b2_ew", 32'(eg_wr), 32'd1);
        tick();
        @(negedge clk);
        chk("mid_rst_ew", 32'(eg_wr), 32'd0);
        chk("mid_rst_sf", 32'(src_full), 32'd3);
        chk("mid_rst_fd", 32'(frames_done), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        resn     = 1'b1;
        src_wr   = 2'b11;
        src_data = 16'h3477;
        @(negedge clk);
        chk("mid_idle_ew", 32'(eg_wr), 32'd0);
        tick();
        @(negedge clk);
        chk("mid_regrant_sf", 32'(src_full), 32'd2);
        chk("mid_regrant_ed", 32'(eg_data), 32'h77);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
